// File: rtl/page_walk_mmu.sv
// Two-level page-walking MMU: READ/WRITE are translated through PDE/PTE reads when paging is on.
// One command in flight; completion is a single-cycle o_rddata_valid pulse in RESP.
module page_walk_mmu #(
   parameter int          MEM_AW     = 16,
   parameter logic [31:0] PDIR_RESET = 32'h0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wrdata,
   input  logic [1:0]        i_size,
   input  logic [3:0]        i_cmd,
   input  logic              i_validcmd,
   input  logic              i_usermode,
   output logic [31:0]       o_rddata,
   output logic              o_rddata_valid,
   output logic [3:0]        o_error,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic              o_mem_re,
   output logic              o_mem_we,
   output logic [3:0]        o_mem_be,
   output logic [31:0]       o_mem_wrdata,
   input  logic [31:0]       i_mem_rddata
);

   localparam logic [2:0] S_IDLE = 3'd0, S_PDE = 3'd1, S_PTE = 3'd2, S_DATA = 3'd3, S_RESP = 3'd4;
   localparam logic [3:0] C_READ = 4'd1, C_WRITE = 4'd2, C_PDIR = 4'd3, C_SPAG = 4'd4;
   localparam logic [3:0] E_NONE = 4'd0, E_ILLEGAL = 4'd1, E_ALIGN = 4'd2;
   localparam logic [3:0] E_NOTPRES = 4'd3, E_RDONLY = 4'd4, E_SUPER = 4'd5;

   logic [2:0]  r_state;
   logic        r_paging;
   logic [19:0] r_pdir;
   logic [31:0] r_va;
   logic [31:0] r_wrdata;
   logic [1:0]  r_size;
   logic        r_is_wr;
   logic        r_user;
   logic        r_walk;
   logic        r_rd_ok;
   logic [3:0]  r_err;
   logic [31:0] r_rddata;

   logic        w_misalign;
   logic [3:0]  w_cmd_err;
   logic [3:0]  w_entry_err;
   logic        w_fault;
   logic [31:0] w_phys;
   logic        w_access;
   logic [31:0] w_shift;
   logic [31:0] w_fmt;
   logic [31:0] w_rddata;
   logic [3:0]  w_be;

   always_comb begin
      w_misalign = (i_size == 2'b10 && i_addr[0]) || (i_size == 2'b11 && i_addr[1:0] != 2'b00);
      w_cmd_err  = E_NONE;
      if (i_cmd < C_READ || i_cmd > C_SPAG)
         w_cmd_err = E_ILLEGAL;
      else if ((i_cmd == C_READ || i_cmd == C_WRITE) && w_misalign)
         w_cmd_err = E_ALIGN;
   end

   // i_mem_rddata holds the PDE in S_PTE and the PTE in S_DATA (walk only)
   always_comb begin
      w_entry_err = E_NONE;
      if (!i_mem_rddata[0])
         w_entry_err = E_NOTPRES;
      else if (r_user && !i_mem_rddata[2])
         w_entry_err = E_SUPER;
      else if (r_is_wr && !i_mem_rddata[1])
         w_entry_err = E_RDONLY;
      w_fault = ((r_state == S_PTE) || (r_state == S_DATA && r_walk)) && (w_entry_err != E_NONE);
   end

   always_comb begin
      w_phys = 32'h0;
      case (r_state)
         S_PDE:   w_phys = {r_pdir, r_va[31:22], 2'b00};
         S_PTE:   w_phys = {i_mem_rddata[31:12], r_va[21:12], 2'b00};
         S_DATA:  w_phys = r_walk ? {i_mem_rddata[31:12], r_va[11:0]} : r_va;
         default: w_phys = 32'h0;
      endcase
   end

   always_comb begin
      case (r_size)
         2'b11:   w_be = 4'b1111;
         2'b10:   w_be = 4'b0011 << r_va[1:0];
         default: w_be = 4'b0001 << r_va[1:0];
      endcase
      case (r_size)
         2'b11:   o_mem_wrdata = r_wrdata;
         2'b10:   o_mem_wrdata = {2{r_wrdata[15:0]}};
         default: o_mem_wrdata = {4{r_wrdata[7:0]}};
      endcase
   end

   // reset gates strobes combinationally so an abandoned walk never touches memory again
   assign w_access   = !i_reset && !w_fault &&
                       (r_state == S_PDE || r_state == S_PTE || r_state == S_DATA);
   assign o_mem_re   = w_access && !(r_state == S_DATA && r_is_wr);
   assign o_mem_we   = w_access && (r_state == S_DATA) && r_is_wr;
   assign o_mem_be   = o_mem_we ? w_be : 4'b0000;
   assign o_mem_addr = w_phys[MEM_AW+1:2];

   always_comb begin
      w_shift = i_mem_rddata >> {r_va[1:0], 3'b000};
      if (r_size == 2'b11)
         w_fmt = i_mem_rddata;
      else if (r_size == 2'b10)
         w_fmt = w_shift & 32'h0000_FFFF;
      else
         w_fmt = w_shift & 32'h0000_00FF;
      w_rddata = r_rddata;
      if (r_state == S_RESP)
         w_rddata = r_rd_ok ? w_fmt : 32'h0;
   end

   assign o_rddata       = w_rddata;
   assign o_rddata_valid = (r_state == S_RESP) && !i_reset;
   assign o_error        = r_err;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_paging <= 1'b0;
         r_pdir   <= PDIR_RESET[31:12];
         r_va     <= 32'h0;
         r_wrdata <= 32'h0;
         r_size   <= 2'b00;
         r_is_wr  <= 1'b0;
         r_user   <= 1'b0;
         r_walk   <= 1'b0;
         r_rd_ok  <= 1'b0;
         r_err    <= E_NONE;
         r_rddata <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_validcmd) begin
                  r_va     <= i_addr;
                  r_wrdata <= i_wrdata;
                  r_size   <= i_size;
                  r_is_wr  <= (i_cmd == C_WRITE);
                  r_user   <= i_usermode;
                  r_walk   <= r_paging;
                  r_rd_ok  <= 1'b0;
                  if (w_cmd_err != E_NONE) begin
                     r_err   <= w_cmd_err;
                     r_state <= S_RESP;
                  end else if (i_cmd == C_PDIR) begin
                     r_pdir  <= i_addr[31:12];
                     r_err   <= E_NONE;
                     r_state <= S_RESP;
                  end else if (i_cmd == C_SPAG) begin
                     r_paging <= i_wrdata[0];
                     r_err    <= E_NONE;
                     r_state  <= S_RESP;
                  end else begin
                     r_state <= r_paging ? S_PDE : S_DATA;
                  end
               end
            end
            S_PDE: r_state <= S_PTE;
            S_PTE: begin
               if (w_fault) begin
                  r_err   <= w_entry_err;
                  r_state <= S_RESP;
               end else begin
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_fault) begin
                  r_err <= w_entry_err;
               end else begin
                  r_err   <= E_NONE;
                  r_rd_ok <= !r_is_wr;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_rddata <= w_rddata;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_page_walk_mmu.sv
// Directed bench for page_walk_mmu: expected completions queued at issue, compared at o_rddata_valid.
module tb_page_walk_mmu;

   localparam logic [3:0] RD = 4'd1, WR = 4'd2, PD = 4'd3, SP = 4'd4;
   localparam logic [1:0] SZB = 2'b00, SZH = 2'b10, SZW = 2'b11;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wrdata = 32'h0;
   logic [1:0]  i_size = 2'b00;
   logic [3:0]  i_cmd = 4'h0;
   logic        i_validcmd = 1'b0;
   logic        i_usermode = 1'b0;
   logic [31:0] o_rddata;
   logic        o_rddata_valid;
   logic [3:0]  o_error;
   logic [15:0] o_mem_addr;
   logic        o_mem_re;
   logic        o_mem_we;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wrdata;
   logic [31:0] i_mem_rddata = 32'h0;

   page_walk_mmu #(.MEM_AW(16), .PDIR_RESET(32'h0)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_addr(i_addr), .i_wrdata(i_wrdata),
      .i_size(i_size), .i_cmd(i_cmd), .i_validcmd(i_validcmd), .i_usermode(i_usermode),
      .o_rddata(o_rddata), .o_rddata_valid(o_rddata_valid), .o_error(o_error),
      .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
      .o_mem_be(o_mem_be), .o_mem_wrdata(o_mem_wrdata), .i_mem_rddata(i_mem_rddata)
   );

   always #5 i_clk = ~i_clk;

   // synchronous memory: data returns the cycle after o_mem_re
   logic [31:0] mem [0:65535];
   int          re_cnt = 0;
   int          we_cnt = 0;
   int          both_cnt = 0;
   logic [15:0] last_raddr = 16'h0;
   logic [3:0]  last_be = 4'h0;

   always @(posedge i_clk) begin
      if (o_mem_re) begin
         i_mem_rddata <= mem[o_mem_addr];
         re_cnt       <= re_cnt + 1;
         last_raddr   <= o_mem_addr;
      end
      if (o_mem_we) begin
         for (int b = 0; b < 4; b++)
            if (o_mem_be[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wrdata[8*b +: 8];
         we_cnt  <= we_cnt + 1;
         last_be <= o_mem_be;
      end
      if (o_mem_re && o_mem_we) both_cnt <= both_cnt + 1;
   end

   typedef struct {
      logic [31:0] data;
      logic [3:0]  err;
      int          lat;
      int          nre;
      int          nwe;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // called at a negedge while the DUT is idle; returns at the negedge after the completion pulse
   task automatic run_cmd(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic usr,
                          input logic [31:0] edata, input logic [3:0] eerr,
                          input int elat, input int enre, input int enwe);
      exp_t e;
      int   re0, we0, lat;
      bit   seen;
      e.data = edata; e.err = eerr; e.lat = elat; e.nre = enre; e.nwe = enwe;
      sb.push_back(e);
      re0 = re_cnt;
      we0 = we_cnt;
      i_cmd = cmd; i_addr = addr; i_wrdata = wd; i_size = sz; i_usermode = usr;
      i_validcmd = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_validcmd = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat <= 12) begin
         if (o_rddata_valid) seen = 1'b1;
         else begin
            @(negedge i_clk);
            lat++;
         end
      end
      e = sb.pop_front();
      check({tag, "_seen"}, 32'(seen), 32'd1);
      check({tag, "_lat"}, lat, e.lat);
      check({tag, "_data"}, o_rddata, e.data);
      check({tag, "_err"}, 32'(o_error), 32'(e.err));
      @(negedge i_clk);
      check({tag, "_pulse"}, 32'(o_rddata_valid), 32'd0);
      check({tag, "_held"}, o_rddata, e.data);
      check({tag, "_nre"}, re_cnt - re0, e.nre);
      check({tag, "_nwe"}, we_cnt - we0, e.nwe);
   endtask

   initial begin
      int re0, we0, bad;
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      check("rst_valid", 32'(o_rddata_valid), 32'd0);
      check("rst_rddata", o_rddata, 32'd0);
      check("rst_error", 32'(o_error), 32'd0);
      check("rst_re", 32'(o_mem_re), 32'd0);
      check("rst_we", 32'(o_mem_we), 32'd0);
      check("rst_be", 32'(o_mem_be), 32'd0);

      // paging off: physical = virtual
      run_cmd("wr_w100", WR, 32'h100, 32'h1122_3344, SZW, 0, 0, 0, 2, 0, 1);
      check("be_word", 32'(last_be), 32'hF);
      run_cmd("rd_b101", RD, 32'h101, 0, SZB, 0, 32'h33, 0, 2, 1, 0);
      check("raddr_off", 32'(last_raddr), 32'h40);
      run_cmd("rd_h102", RD, 32'h102, 0, SZH, 0, 32'h1122, 0, 2, 1, 0);
      run_cmd("rd_w100", RD, 32'h100, 0, SZW, 0, 32'h1122_3344, 0, 2, 1, 0);
      run_cmd("wr_w200", WR, 32'h200, 32'h0, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("wr_h200", WR, 32'h200, 32'h0000_BEEF, SZH, 0, 0, 0, 2, 0, 1);
      check("be_half", 32'(last_be), 32'h3);
      run_cmd("wr_b203", WR, 32'h203, 32'h0000_00AB, SZB, 0, 0, 0, 2, 0, 1);
      check("be_byte", 32'(last_be), 32'h8);
      run_cmd("rd_w200", RD, 32'h200, 0, SZW, 0, 32'hAB00_BEEF, 0, 2, 1, 0);

      run_cmd("mis_h3", WR, 32'h3, 32'h1, SZH, 0, 0, 2, 1, 0, 0);
      run_cmd("mis_w2", RD, 32'h2, 0, SZW, 0, 0, 2, 1, 0, 0);
      run_cmd("ill_7", 4'd7, 32'h100, 0, SZW, 0, 0, 1, 1, 0, 0);
      run_cmd("ill_0", 4'd0, 32'h100, 0, SZW, 0, 0, 1, 1, 0, 0);

      // page tables: PDE @0x2000, PTE @0x3004, data page 0x5000
      run_cmd("set_pde", WR, 32'h2000, 32'h3007, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("set_pte", WR, 32'h3004, 32'h5007, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("set_dat", WR, 32'h5008, 32'hCAFE_F00D, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("pdir", PD, 32'h2000, 0, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("spag1", SP, 32'h0, 32'h1, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("walk_rd", RD, 32'h1008, 0, SZW, 0, 32'hCAFE_F00D, 0, 4, 3, 0);
      check("walk_raddr", 32'(last_raddr), 32'h1402);
      run_cmd("walk_wrb", WR, 32'h1011, 32'h5A, SZB, 1, 0, 0, 4, 2, 1);
      check("walk_be", 32'(last_be), 32'h2);
      run_cmd("walk_rdb", RD, 32'h1011, 0, SZB, 0, 32'h5A, 0, 4, 3, 0);

      // read-only PTE
      run_cmd("spag0a", SP, 32'h0, 32'h0, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("pte_ro", WR, 32'h3004, 32'h5005, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("spag1a", SP, 32'h0, 32'h1, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("ro_wr", WR, 32'h1000, 32'h1234_5678, SZW, 0, 0, 4, 4, 2, 0);
      run_cmd("ro_rd", RD, 32'h1008, 0, SZW, 0, 32'hCAFE_F00D, 0, 4, 3, 0);

      // supervisor PTE, user request
      run_cmd("spag0b", SP, 32'h0, 32'h0, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("pte_sup", WR, 32'h3004, 32'h5003, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("spag1b", SP, 32'h0, 32'h1, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("sup_rd", RD, 32'h1008, 0, SZW, 1, 0, 5, 4, 2, 0);

      // PDE faults: not present wins over user check
      run_cmd("spag0c", SP, 32'h0, 32'h0, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("pte_ok", WR, 32'h3004, 32'h5007, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("pde_np", WR, 32'h2000, 32'h3006, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("spag1c", SP, 32'h0, 32'h1, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("np_rd", RD, 32'h1008, 0, SZW, 0, 0, 3, 3, 1, 0);
      run_cmd("np_usr", RD, 32'h1008, 0, SZW, 1, 0, 3, 3, 1, 0);
      run_cmd("spag0d", SP, 32'h0, 32'h0, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("pde_sup", WR, 32'h2000, 32'h3003, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("spag1d", SP, 32'h0, 32'h1, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("pde_usr", RD, 32'h1008, 0, SZW, 1, 0, 5, 3, 1, 0);
      run_cmd("spag0e", SP, 32'h0, 32'h0, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("pde_ok", WR, 32'h2000, 32'h3007, SZW, 0, 0, 0, 2, 0, 1);
      run_cmd("spag1e", SP, 32'h0, 32'h1, SZW, 0, 0, 0, 1, 0, 0);
      run_cmd("pre_rst", RD, 32'h1008, 0, SZW, 0, 32'hCAFE_F00D, 0, 4, 3, 0);

      // reset while the walk is in PTE
      re0 = re_cnt;
      we0 = we_cnt;
      i_cmd = RD; i_addr = 32'h1008; i_size = SZW; i_usermode = 1'b0;
      i_validcmd = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_validcmd = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      check("rst2_rddata", o_rddata, 32'd0);
      check("rst2_error", 32'(o_error), 32'd0);
      bad = 0;
      repeat (6) begin
         if (o_rddata_valid || o_mem_re || o_mem_we) bad++;
         @(negedge i_clk);
      end
      check("rst2_quiet", bad, 0);
      check("rst2_nre", re_cnt - re0, 1);
      check("rst2_nwe", we_cnt - we0, 0);
      run_cmd("post_rst", RD, 32'h101, 0, SZB, 0, 32'h33, 0, 2, 1, 0);
      check("post_raddr", 32'(last_raddr), 32'h40);

      check("never_both", both_cnt, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
